st_bus_scheduler: RTL

Frame-aligned slot scheduler for the ST-bus converter. It locks onto the 8 kHz active-low frame pulse `f0` in the 4.096 MHz `c4` domain and tracks the 512-cycle frame position. From that it generates per-timeslot enables for the converter's TX and RX paths using software-loaded 32-slot masks. It also applies converter mode (`select`) changes only on frame boundaries, so the converter never switches mid-frame.

---
 rtl/st_bus_scheduler_pkg.sv | 25 ++
 rtl/st_bus_scheduler_frame_lock.sv | 125 ++++++++++++
 rtl/st_bus_scheduler.sv | 103 ++++++++++
 3 files changed

// File: rtl/st_bus_scheduler_pkg.sv
// Shared ST-bus frame geometry, counter field widths and the lock-state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package st_bus_pkg;

   localparam int FRAME_LEN   = 512;
   localparam int NUM_SLOTS   = 32;
   localparam int CYC_PER_BIT = 2;

   localparam int CNT_W   = $clog2(FRAME_LEN);
   localparam int SLOT_W  = $clog2(NUM_SLOTS);
   localparam int BIT_LSB = $clog2(CYC_PER_BIT);
   localparam int BIT_W   = $clog2(FRAME_LEN / (NUM_SLOTS * CYC_PER_BIT));

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } lock_state_e;

   function automatic logic is_frame_end(input logic [CNT_W-1:0] c);
      return c == CNT_W'(FRAME_LEN - 1);
   endfunction

endpackage

// File: rtl/st_bus_scheduler_frame_lock.sv
// Frame counter plus f0 lock filter (HUNT/CHECK/LOCKED when FRAME_LOCK_EN is defined).
// Latency: f0 sampled low at edge k gives cnt==0 after edge k; lock outputs registered.
// Backpressure: none; the counter free-runs on every c4 edge.
module st_bus_frame_lock
   import st_bus_pkg::*;
#(
   parameter int LOCK_GOOD = 2,
   parameter int LOCK_MISS = 2
) (
   input  logic             c4,
   input  logic             rst,
   input  logic             f0,
   output logic [CNT_W-1:0] cnt_o,
   output logic             locked_o,
   output logic             lock_lost_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             locked_q, locked_d;
   logic             frame_edge;

   assign frame_edge = ~f0;
   assign cnt_o      = cnt_q;
   assign locked_o   = locked_q;

`ifdef FRAME_LOCK_EN
   localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
   localparam int MISS_W = $clog2(LOCK_MISS + 1);

   lock_state_e       state_q, state_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic              lost_q, lost_d;
   logic              at_end;

   assign at_end      = is_frame_end(cnt_q);
   assign lock_lost_o = lost_q;

   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      state_d  = state_q;
      good_d   = good_q;
      miss_d   = miss_q;
      locked_d = locked_q;
      lost_d   = 1'b0;
      case (state_q)
         HUNT: begin
            if (frame_edge) begin
               cnt_d   = '0;
               good_d  = '0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (frame_edge && at_end) begin
               if (int'(good_q) + 1 >= LOCK_GOOD) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                  miss_d   = '0;
               end else begin
                  good_d = good_q + 1'b1;
               end
            end else if (frame_edge) begin
               cnt_d  = '0;
               good_d = '0;
            end else if (at_end) begin
               state_d = HUNT;
            end
         end
         LOCKED: begin
            // Once locked the counter is never realigned; stray pulses only count as misses.
            if (frame_edge && at_end) begin
               miss_d = '0;
            end else if (frame_edge || at_end) begin
               if (int'(miss_q) + 1 >= LOCK_MISS) begin
                  state_d  = HUNT;
                  locked_d = 1'b0;
                  lost_d   = 1'b1;
                  miss_d   = '0;
               end else begin
                  miss_d = miss_q + 1'b1;
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge c4 or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         state_q  <= HUNT;
         good_q   <= '0;
         miss_q   <= '0;
         locked_q <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         good_q   <= good_d;
         miss_q   <= miss_d;
         locked_q <= locked_d;
         lost_q   <= lost_d;
      end
   end
`else
   assign lock_lost_o = 1'b0;

   always_comb begin
      cnt_d    = frame_edge ? '0 : cnt_q + 1'b1;
      locked_d = locked_q | frame_edge;
   end

   always_ff @(posedge c4 or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
      end
   end
`endif

endmodule

// File: rtl/st_bus_scheduler.sv
// ST-bus slot scheduler: slot/bit position, per-slot TX/RX enables, frame-aligned masks and mode select.
// Latency: all outputs registered or decoded from the registered counter; masks/select apply at cnt==0.
// Backpressure: none; cfg_wr always accepted. Lock filter built only with FRAME_LOCK_EN defined.
module st_bus_scheduler
   import st_bus_pkg::*;
#(
   parameter int LOCK_GOOD = 2,
   parameter int LOCK_MISS = 2
) (
   input  logic                 c4,
   input  logic                 rst,
   input  logic                 f0,
   input  logic                 sel_req,
   input  logic                 cfg_wr,
   input  logic                 cfg_dir,
   input  logic [NUM_SLOTS-1:0] cfg_mask,
   output logic                 cfg_ack,
   output logic                 select,
   output logic [SLOT_W-1:0]    slot,
   output logic [BIT_W-1:0]     bit_idx,
   output logic                 frame_start,
   output logic                 clk_en_tx,
   output logic                 clk_en_rx,
   output logic                 locked,
   output logic                 lock_lost
);

   logic [CNT_W-1:0]     cnt;
   logic                 frame_end;
   logic [NUM_SLOTS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic [NUM_SLOTS-1:0] tx_act_q, tx_act_d, rx_act_q, rx_act_d;
   logic                 pend_q, pend_d;
   logic                 ack_q, ack_d;
   logic                 sel_q, sel_d;

   st_bus_frame_lock #(
      .LOCK_GOOD (LOCK_GOOD),
      .LOCK_MISS (LOCK_MISS)
   ) u_frame_lock (
      .c4          (c4),
      .rst         (rst),
      .f0          (f0),
      .cnt_o       (cnt),
      .locked_o    (locked),
      .lock_lost_o (lock_lost)
   );

   assign frame_end = is_frame_end(cnt);

   // Transfer reads the old shadow, so a write landing on the transfer edge waits a frame.
   always_comb begin
      tx_sh_d  = tx_sh_q;
      rx_sh_d  = rx_sh_q;
      tx_act_d = tx_act_q;
      rx_act_d = rx_act_q;
      pend_d   = pend_q;
      ack_d    = 1'b0;
      sel_d    = sel_q;
      if (frame_end) begin
         sel_d = sel_req;
         if (pend_q) begin
            tx_act_d = tx_sh_q;
            rx_act_d = rx_sh_q;
            pend_d   = 1'b0;
            ack_d    = 1'b1;
         end
      end
      if (cfg_wr) begin
         if (cfg_dir) rx_sh_d = cfg_mask;
         else         tx_sh_d = cfg_mask;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge c4 or posedge rst) begin
      if (rst) begin
         tx_sh_q  <= '0;
         rx_sh_q  <= '0;
         tx_act_q <= '0;
         rx_act_q <= '0;
         pend_q   <= 1'b0;
         ack_q    <= 1'b0;
         sel_q    <= 1'b0;
      end else begin
         tx_sh_q  <= tx_sh_d;
         rx_sh_q  <= rx_sh_d;
         tx_act_q <= tx_act_d;
         rx_act_q <= rx_act_d;
         pend_q   <= pend_d;
         ack_q    <= ack_d;
         sel_q    <= sel_d;
      end
   end

   assign cfg_ack     = ack_q;
   assign select      = sel_q;
   assign slot        = cnt[CNT_W-1 -: SLOT_W];
   assign bit_idx     = cnt[BIT_LSB +: BIT_W];
   assign frame_start = (cnt == '0);
   assign clk_en_tx   = locked & tx_act_q[slot];
   assign clk_en_rx   = locked & rx_act_q[slot];

endmodule
